// File: rtl/uart_tx_scheduler.sv
// Arbitrates one uarttx transmitter between a buffered keyboard byte stream and an
// auxiliary valid/ready source, pacing sends by counting baud ticks per frame.
module uart_tx_scheduler #(
    parameter int FIFO_DEPTH  = 4,
    parameter int FRAME_TICKS = 10,
    parameter int GAP_TICKS   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txclk_en,
    input  logic       kb_push,
    input  logic [7:0] kb_data,
    output logic       kb_overflow,
    input  logic       aux_valid,
    input  logic [7:0] aux_data,
    output logic       aux_ready,
    output logic       usend,
    output logic [7:0] ucode,
    output logic       busy
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int TICK_W = $clog2(FRAME_TICKS + GAP_TICKS + 2);
    localparam logic [TICK_W-1:0] WAIT_LOAD = TICK_W'(FRAME_TICKS + GAP_TICKS);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {SRC_KB, SRC_AUX} src_t;

    state_t            state_reg;
    src_t              last_grant_reg;
    logic [TICK_W-1:0] tick_cnt_reg;
    logic              usend_reg;
    logic [7:0]        ucode_reg;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;

    logic fifo_empty;
    logic fifo_full;
    logic in_idle;
    logic grant_kb;
    logic grant_aux;
    logic pop;
    logic push_ok;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_CNT);

    // A grant is only issued in IDLE and never while reset is held, so aux_ready
    // cannot promise a handshake that the reset would swallow.
    assign in_idle   = (state_reg == IDLE) && !rst;
    assign grant_kb  = in_idle && !fifo_empty && (!aux_valid || last_grant_reg == SRC_AUX);
    assign grant_aux = in_idle && aux_valid && (fifo_empty || last_grant_reg == SRC_KB);

    assign pop     = grant_kb;
    assign push_ok = kb_push && (!fifo_full || pop);

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push_ok) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    assign kb_overflow = !rst && kb_push && fifo_full && !pop;
    assign aux_ready   = grant_aux;
    assign usend       = usend_reg;
    assign ucode       = ucode_reg;
    assign busy        = (state_reg != IDLE);

    // Storage has no reset so it maps onto a RAM; a write to a full FIFO during a
    // pop lands in the slot being read, and the read still sees the old byte.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= kb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= WAIT;
            tick_cnt_reg   <= WAIT_LOAD;
            last_grant_reg <= SRC_AUX;
            usend_reg      <= 1'b0;
            ucode_reg      <= 8'h00;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            usend_reg <= 1'b0;
            count_reg <= count_next;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (grant_kb) begin
                        usend_reg      <= 1'b1;
                        ucode_reg      <= fifo_mem[rd_ptr_reg];
                        last_grant_reg <= SRC_KB;
                        tick_cnt_reg   <= WAIT_LOAD;
                        state_reg      <= WAIT;
                    end else if (grant_aux) begin
                        usend_reg      <= 1'b1;
                        ucode_reg      <= aux_data;
                        last_grant_reg <= SRC_AUX;
                        tick_cnt_reg   <= WAIT_LOAD;
                        state_reg      <= WAIT;
                    end
                end
                WAIT: begin
                    // The tick in the send cycle belongs to uarttx leaving its idle state.
                    if (txclk_en && !usend_reg) begin
                        if (tick_cnt_reg <= TICK_W'(1)) begin
                            tick_cnt_reg <= '0;
                            state_reg    <= IDLE;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg - TICK_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= WAIT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench: scoreboard of expected transmit bytes plus per-scenario timing checks.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txclk_en = 1'b0;
    logic       kb_push = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       aux_valid = 1'b0;
    logic [7:0] aux_data = 8'h00;
    logic       kb_overflow, aux_ready, usend, busy;
    logic [7:0] ucode;

    logic       g_rst = 1'b1;
    logic       g_push = 1'b0;
    logic [7:0] g_data = 8'h00;
    logic       g_aux_valid = 1'b0;
    logic [7:0] g_aux_data = 8'h00;
    logic       g_overflow, g_aux_ready, g_usend, g_busy;
    logic [7:0] g_ucode;

    int vectors = 0;
    int miscompares = 0;
    int aux_pulses = 0;
    logic [7:0] sb[$];
    logic prev_usend = 1'b0;

    uart_tx_scheduler #(.FIFO_DEPTH(4), .FRAME_TICKS(10), .GAP_TICKS(0)) dut (
        .clk(clk), .rst(rst), .txclk_en(txclk_en),
        .kb_push(kb_push), .kb_data(kb_data), .kb_overflow(kb_overflow),
        .aux_valid(aux_valid), .aux_data(aux_data), .aux_ready(aux_ready),
        .usend(usend), .ucode(ucode), .busy(busy)
    );

    uart_tx_scheduler #(.FIFO_DEPTH(4), .FRAME_TICKS(10), .GAP_TICKS(2)) dut_gap (
        .clk(clk), .rst(g_rst), .txclk_en(txclk_en),
        .kb_push(g_push), .kb_data(g_data), .kb_overflow(g_overflow),
        .aux_valid(g_aux_valid), .aux_data(g_aux_data), .aux_ready(g_aux_ready),
        .usend(g_usend), .ucode(g_ucode), .busy(g_busy)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk in four.
    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            div = (div + 1) % 4;
            txclk_en = (div == 0);
        end
    end

    // Scoreboard monitor: every send must match the next expected byte.
    initial begin : monitor
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (usend === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_send: ucode=%h, no byte expected", ucode);
                end else begin
                    exp_b = sb.pop_front();
                    $display("send ucode=%h expected=%h", ucode, exp_b);
                    if (ucode !== exp_b) begin
                        miscompares++;
                        $display("FAIL send_byte: ucode=%h required=%h", ucode, exp_b);
                    end
                end
                vectors++;
                if (prev_usend !== 1'b0) begin
                    miscompares++;
                    $display("FAIL usend_width: usend high 2 cycles, required 1");
                end
            end
            if (aux_ready === 1'b1) begin
                aux_pulses++;
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL aux_ready_idle: aux_ready=1 with busy=%b, required busy=0", busy);
                end
            end
            prev_usend = usend;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns at the negedge of the next usend cycle; counts DUT-visible ticks before it.
    task automatic wait_send(input int bound, output int ticks, output bit ok);
        ticks = 0;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (usend === 1'b1) begin
                ok = 1'b1;
            end else begin
                if (txclk_en && !rst) ticks++;
                step();
                kb_push = 1'b0;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: no usend in %0d cycles, required one", bound);
        end
    endtask

    task automatic wait_idle(input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: busy=%b pending=%0d, required idle", busy, sb.size());
        end
    endtask

    task automatic aux_handshake(input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (aux_ready === 1'b1) begin
                step();
                aux_valid = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            aux_valid = 1'b0;
            vectors++;
            miscompares++;
            $display("FAIL aux_timeout: aux_ready never seen in %0d cycles", bound);
        end
    endtask

    task automatic check_reset_values(input string tag);
        vectors++;
        if (usend !== 1'b0) begin miscompares++; $display("FAIL %s_usend: %b required 0", tag, usend); end
        vectors++;
        if (ucode !== 8'h00) begin miscompares++; $display("FAIL %s_ucode: %h required 00", tag, ucode); end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL %s_busy: %b required 1", tag, busy); end
        vectors++;
        if (aux_ready !== 1'b0) begin miscompares++; $display("FAIL %s_aux_ready: %b required 0", tag, aux_ready); end
        vectors++;
        if (kb_overflow !== 1'b0) begin miscompares++; $display("FAIL %s_overflow: %b required 0", tag, kb_overflow); end
    endtask

    task automatic test_reset();
        int t;
        bit ok;
        step(); step(); step();
        @(negedge clk);
        check_reset_values("reset");
        step();
        rst = 1'b0;
        kb_push = 1'b1;
        kb_data = 8'h61;
        sb.push_back(8'h61);
        wait_send(500, t, ok);
        vectors++;
        if (ok && t !== 10) begin
            miscompares++;
            $display("FAIL reset_wait: %0d ticks before first send, required 10", t);
        end
    endtask

    task automatic test_single();
        int n;
        wait_idle(500);
        step();
        kb_push = 1'b1;
        kb_data = 8'h41;
        sb.push_back(8'h41);
        @(negedge clk);
        vectors++;
        if (usend !== 1'b0) begin miscompares++; $display("FAIL single_lat0: usend=%b required 0", usend); end
        step();
        kb_push = 1'b0;
        @(negedge clk);
        vectors++;
        if (usend !== 1'b0) begin miscompares++; $display("FAIL single_lat1: usend=%b required 0", usend); end
        @(negedge clk);
        vectors++;
        if (usend !== 1'b1) begin miscompares++; $display("FAIL single_lat2: usend=%b required 1", usend); end
        @(negedge clk);
        vectors++;
        if (usend !== 1'b0) begin miscompares++; $display("FAIL single_pulse: usend=%b required 0", usend); end
        n = 0;
        for (int i = 0; i < 200 && busy === 1'b1; i++) begin
            if (txclk_en) n++;
            @(negedge clk);
        end
        vectors++;
        if (n !== 10) begin miscompares++; $display("FAIL single_busy_ticks: %0d required 10", n); end
    endtask

    task automatic test_back_to_back();
        int t;
        bit ok;
        wait_idle(500);
        step();
        kb_push = 1'b1; kb_data = 8'h21; sb.push_back(8'h21);
        step();
        kb_data = 8'h22; sb.push_back(8'h22);
        step();
        kb_push = 1'b0;
        wait_send(500, t, ok);
        wait_send(500, t, ok);
        vectors++;
        if (ok && t !== 10) begin miscompares++; $display("FAIL b2b_ticks: %0d required 10", t); end
    endtask

    task automatic test_arbitration();
        int p0;
        wait_idle(500);
        step();
        aux_valid = 1'b1; aux_data = 8'hA0; sb.push_back(8'hA0);
        aux_handshake(50);
        kb_push = 1'b1; kb_data = 8'h10;
        step();
        kb_data = 8'h11;
        step();
        kb_push = 1'b0;
        aux_valid = 1'b1; aux_data = 8'h55;
        sb.push_back(8'h10); sb.push_back(8'h55); sb.push_back(8'h11);
        p0 = aux_pulses;
        aux_handshake(500);
        wait_idle(1000);
        vectors++;
        if (aux_pulses - p0 !== 1) begin
            miscompares++;
            $display("FAIL arb_aux_pulses: %0d required 1", aux_pulses - p0);
        end
    endtask

    task automatic test_overflow();
        int t;
        bit ok;
        wait_idle(500);
        step();
        kb_push = 1'b1; kb_data = 8'h31; sb.push_back(8'h31);
        step();
        kb_push = 1'b0;
        wait_send(500, t, ok);
        for (int b = 2; b <= 6; b++) begin
            step();
            kb_push = 1'b1;
            kb_data = 8'(8'h30 + b);
            if (b <= 5) sb.push_back(8'(8'h30 + b));
            @(negedge clk);
            vectors++;
            if (kb_overflow !== (b == 6)) begin
                miscompares++;
                $display("FAIL overflow_push%0d: kb_overflow=%b required %b", b, kb_overflow, (b == 6));
            end
        end
        step();
        kb_push = 1'b0;
        wait_idle(1500);
    endtask

    task automatic test_full_pop();
        int t, n, k;
        bit ok;
        wait_idle(500);
        step();
        kb_push = 1'b1; kb_data = 8'hF0; sb.push_back(8'hF0);
        step();
        kb_push = 1'b0;
        wait_send(500, t, ok);
        n = 0;
        k = 1;
        for (int i = 0; i < 200 && n < 10; i++) begin
            step();
            if (k <= 4) begin
                kb_push = 1'b1;
                kb_data = 8'(8'hF0 + k);
                sb.push_back(8'(8'hF0 + k));
                k++;
            end else begin
                kb_push = 1'b0;
            end
            @(negedge clk);
            if (txclk_en) n++;
        end
        vectors++;
        if (n !== 10) begin miscompares++; $display("FAIL fullpop_ticks: %0d counted, required 10", n); end
        step();
        kb_push = 1'b1; kb_data = 8'hF5; sb.push_back(8'hF5);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL fullpop_idle: busy=%b required 0", busy); end
        vectors++;
        if (kb_overflow !== 1'b0) begin miscompares++; $display("FAIL fullpop_overflow: %b required 0", kb_overflow); end
        step();
        kb_data = 8'hF6;
        @(negedge clk);
        vectors++;
        if (usend !== 1'b1) begin miscompares++; $display("FAIL fullpop_grant: usend=%b required 1", usend); end
        vectors++;
        if (kb_overflow !== 1'b1) begin miscompares++; $display("FAIL fullpop_still_full: kb_overflow=%b required 1", kb_overflow); end
        step();
        kb_push = 1'b0;
        wait_idle(1500);
    endtask

    task automatic test_reset_mid();
        int t, n;
        bit ok;
        wait_idle(500);
        step();
        kb_push = 1'b1; kb_data = 8'hB1; sb.push_back(8'hB1);
        step();
        kb_push = 1'b0;
        wait_send(500, t, ok);
        n = 0;
        for (int i = 0; i < 200 && n < 5; i++) begin
            step();
            kb_push = (i == 0);
            kb_data = 8'hB2;
            @(negedge clk);
            if (txclk_en) n++;
        end
        step();
        kb_push = 1'b0;
        rst = 1'b1;
        step();
        @(negedge clk);
        check_reset_values("midrst");
        step();
        rst = 1'b0;
        kb_push = 1'b1; kb_data = 8'hB3; sb.push_back(8'hB3);
        wait_send(500, t, ok);
        vectors++;
        if (ok && t !== 10) begin miscompares++; $display("FAIL midrst_wait: %0d ticks, required 10", t); end
        wait_idle(500);
    endtask

    task automatic test_gap();
        int n, sends;
        int gap [2];
        logic [7:0] code [2];
        n = 0;
        sends = 0;
        gap[0] = -1; gap[1] = -1;
        code[0] = 8'h00; code[1] = 8'h00;
        for (int i = 0; i < 400 && sends < 2; i++) begin
            step();
            case (i)
                0: begin g_rst = 1'b0; g_push = 1'b1; g_data = 8'hC1; end
                1: g_data = 8'hC2;
                2: g_push = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            if (g_usend === 1'b1) begin
                gap[sends] = n;
                code[sends] = g_ucode;
                $display("gap send ucode=%h after %0d ticks", g_ucode, n);
                sends++;
                n = 0;
            end else if (txclk_en) begin
                n++;
            end
        end
        vectors++;
        if (sends !== 2) begin miscompares++; $display("FAIL gap_sends: %0d required 2", sends); end
        vectors++;
        if (gap[0] !== 12) begin miscompares++; $display("FAIL gap_reset_wait: %0d required 12", gap[0]); end
        vectors++;
        if (gap[1] !== 12) begin miscompares++; $display("FAIL gap_spacing: %0d required 12", gap[1]); end
        vectors++;
        if (code[0] !== 8'hC1) begin miscompares++; $display("FAIL gap_byte0: %h required c1", code[0]); end
        vectors++;
        if (code[1] !== 8'hC2) begin miscompares++; $display("FAIL gap_byte1: %h required c2", code[1]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_arbitration();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_gap();
        repeat (60) @(negedge clk);
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d bytes never sent, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
